// File: rtl/femto_pll_reset_seq.sv
// Boot and relock sequencer for the iCE40 SB_PLL40_CORE, clocked from the board clock.
// Drives PLL RESETB, filters LOCK, and holds the system reset until lock is stable.
module femto_pll_reset_seq #(
   parameter int RST_CYCLES   = 16,
   parameter int LOCK_TIMEOUT = 4096,
   parameter int LOCK_STABLE  = 256,
   parameter int MAX_RETRY    = 3
) (
   input  logic       pclk,
   input  logic       reset,
   input  logic       pll_lock,
   input  logic       soft_restart,
   output logic       pll_resetb,
   output logic       sys_reset,
   output logic       locked,
   output logic       fail,
   output logic [3:0] retry_count,
   output logic [7:0] loss_count
);

   localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE) ? CNT_MAX_A : LOCK_STABLE;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   // The WAIT_LOCK cycle that first sees lock_s is the first cycle of the stable run.
   localparam logic [CNT_W-1:0] FILT_LAST    = CNT_W'((LOCK_STABLE >= 2) ? LOCK_STABLE - 2 : 0);
   localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRY);

   typedef enum logic [2:0] {
      ST_PLL_RST   = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_LOCK_FILT = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAIL      = 3'd4
   } state_t;

   state_t           state;
   state_t           state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic [3:0]       retry_n;
   logic [7:0]       loss_n;
   logic             lock_m;
   logic             lock_s;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      retry_n = retry_count;
      loss_n  = loss_count;
      case (state)
         ST_PLL_RST: begin
            cnt_n = cnt + CNT_W'(1);
            if (cnt == RST_LAST) begin
               state_n = ST_WAIT_LOCK;
            end
         end
         ST_WAIT_LOCK: begin
            cnt_n = cnt + CNT_W'(1);
            if (lock_s) begin
               if (LOCK_STABLE <= 1) begin
                  state_n = ST_RUN;
                  retry_n = 4'd0;
               end else begin
                  state_n = ST_LOCK_FILT;
               end
            end else if (cnt == TIMEOUT_LAST) begin
               if (retry_count == RETRY_LIMIT) begin
                  state_n = ST_FAIL;
               end else begin
                  state_n = ST_PLL_RST;
                  retry_n = retry_count + 4'd1;
               end
            end
         end
         ST_LOCK_FILT: begin
            cnt_n = cnt + CNT_W'(1);
            if (!lock_s) begin
               state_n = ST_WAIT_LOCK;
            end else if (cnt == FILT_LAST) begin
               state_n = ST_RUN;
               retry_n = 4'd0;
            end
         end
         ST_RUN: begin
            if (!lock_s) begin
               state_n = ST_PLL_RST;
               if (loss_count != 8'hFF) begin
                  loss_n = loss_count + 8'd1;
               end
            end
         end
         ST_FAIL: begin
            state_n = ST_FAIL;
         end
         default: begin
            state_n = ST_PLL_RST;
         end
      endcase

      // A restart overrides whatever lock/timeout decision was made above.
      if (soft_restart) begin
         state_n = ST_PLL_RST;
         retry_n = 4'd0;
         loss_n  = loss_count;
      end

      if (soft_restart || (state_n != state)) begin
         cnt_n = '0;
      end
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge pclk or posedge reset) begin
      if (reset) begin
         lock_m      <= 1'b0;
         lock_s      <= 1'b0;
         state       <= ST_PLL_RST;
         cnt         <= '0;
         retry_count <= 4'd0;
         loss_count  <= 8'd0;
         pll_resetb  <= 1'b0;
         sys_reset   <= 1'b1;
         locked      <= 1'b0;
         fail        <= 1'b0;
      end else begin
         lock_m      <= pll_lock;
         lock_s      <= lock_m;
         state       <= state_n;
         cnt         <= cnt_n;
         retry_count <= retry_n;
         loss_count  <= loss_n;
         pll_resetb  <= !((state_n == ST_PLL_RST) || (state_n == ST_FAIL));
         sys_reset   <= (state_n != ST_RUN);
         locked      <= (state_n == ST_RUN);
         fail        <= (state_n == ST_FAIL);
      end
   end

endmodule
